// File: rtl/dsp_fp16_pkg.sv
// dsp_fp16_pkg: shared fp16 divider-family widths, table sizes, constants and loader state codes
package dsp_fp16_pkg;
  localparam int FLOAT_LEN = 16;
  localparam int EXP_LEN = 5;
  localparam int MANT_LEN = 10;
  localparam int LUT_SIZE = 128;
  localparam int DRAIN_CYC = 2;
  localparam logic [15:0] FP16_ZERO = 16'h0000;
  localparam logic [15:0] FP16_ONE = 16'h3C00;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;
endpackage

// File: rtl/lut_init_loader_if.sv
// lut_init_loader_if: entry stream (in_valid/in_ready/in_log2/in_exp2) plus divider LUT write pins (lut_wr_en/log2/exp2 data)
interface lut_init_loader_if #(
  parameter int FLOAT_LEN = dsp_fp16_pkg::FLOAT_LEN,
  parameter int MANT_LEN = dsp_fp16_pkg::MANT_LEN
);
  logic in_valid, in_ready, lut_wr_en;
  logic [MANT_LEN-1:0] in_log2, log2_lut_data_out;
  logic [FLOAT_LEN-1:0] in_exp2, exp2_lut_data_out;
  modport master (
    output in_valid, in_log2, in_exp2,
    input in_ready, lut_wr_en, log2_lut_data_out, exp2_lut_data_out
  );
  modport slave (
    input in_valid, in_log2, in_exp2,
    output in_ready, lut_wr_en, log2_lut_data_out, exp2_lut_data_out
  );
endinterface

// File: rtl/lut_init_loader.sv
// lut_init_loader: one-shot LUT loader; ports clk, rst_n, start, bus (entry stream + LUT write pins), busy, lut_ready, overrun, load_count
module lut_init_loader #(
  parameter int FLOAT_LEN = dsp_fp16_pkg::FLOAT_LEN,
  parameter int MANT_LEN = dsp_fp16_pkg::MANT_LEN,
  parameter int LUT_SIZE = dsp_fp16_pkg::LUT_SIZE,
  parameter int DRAIN_CYC = dsp_fp16_pkg::DRAIN_CYC,
  localparam int CW = $clog2(LUT_SIZE) + 1
) (
  input logic clk,
  input logic rst_n,
  input logic start,
  lut_init_loader_if.slave bus,
  output logic busy,
  output logic lut_ready,
  output logic overrun,
  output logic [CW-1:0] load_count
);
  import dsp_fp16_pkg::*;
  localparam int DW = $clog2(DRAIN_CYC + 2);
  logic [1:0] state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [DW-1:0] drain_q, drain_d;
  logic wr_q, wr_d, ovr_q, ovr_d, acc, last;
  logic [MANT_LEN-1:0] log2_q, log2_d;
  logic [FLOAT_LEN-1:0] exp2_q, exp2_d;
  always_comb begin
    acc = state_q == ST_LOAD && bus.in_valid;
    last = acc && count_q == CW'(LUT_SIZE - 1);
    state_d = state_q == ST_IDLE ? (start ? ST_LOAD : ST_IDLE)
            : state_q == ST_LOAD ? (last ? ST_DRAIN : ST_LOAD)
            : state_q == ST_DRAIN ? (drain_q == DW'(DRAIN_CYC) ? ST_DONE : ST_DRAIN)
            : ST_DONE;
    drain_d = state_q == ST_DRAIN ? drain_q + 1'b1 : '0;
    count_d = acc && count_q != CW'(LUT_SIZE) ? count_q + 1'b1 : count_q;
    wr_d = acc;
    log2_d = acc ? bus.in_log2 : log2_q;
    exp2_d = acc ? bus.in_exp2 : exp2_q;
    ovr_d = ovr_q | (state_q == ST_DONE && bus.in_valid);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      drain_q <= '0;
      wr_q <= 1'b0;
      ovr_q <= 1'b0;
      log2_q <= '0;
      exp2_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      drain_q <= drain_d;
      wr_q <= wr_d;
      ovr_q <= ovr_d;
      log2_q <= log2_d;
      exp2_q <= exp2_d;
    end
  end
  assign bus.in_ready = state_q == ST_LOAD;
  assign bus.lut_wr_en = wr_q;
  assign bus.log2_lut_data_out = log2_q;
  assign bus.exp2_lut_data_out = exp2_q;
  assign busy = state_q == ST_LOAD || state_q == ST_DRAIN;
  assign lut_ready = state_q == ST_DONE;
  assign overrun = ovr_q;
  assign load_count = count_q;
endmodule

// File: tb/tb_lut_init_loader.sv
// tb_lut_init_loader: randomized self-checking bench for lut_init_loader
module tb_lut_init_loader;
  import dsp_fp16_pkg::*;
  localparam int CW = $clog2(LUT_SIZE) + 1;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic busy, lut_ready, overrun;
  logic [CW-1:0] load_count;
  int total = 0, bad = 0;
  logic [MANT_LEN-1:0] s_log2 [LUT_SIZE];
  logic [FLOAT_LEN-1:0] s_exp2 [LUT_SIZE];
  lut_init_loader_if #(.FLOAT_LEN(FLOAT_LEN), .MANT_LEN(MANT_LEN)) bus ();
  lut_init_loader #(.FLOAT_LEN(FLOAT_LEN), .MANT_LEN(MANT_LEN), .LUT_SIZE(LUT_SIZE), .DRAIN_CYC(DRAIN_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(bus.slave),
    .busy(busy), .lut_ready(lut_ready), .overrun(overrun), .load_count(load_count)
  );
  always #5 clk = ~clk;
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    start = 1'b0;
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #3 rst_n = 1'b1;
    step();
  endtask
  task automatic begin_load;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask
  task automatic test_reset;
    bus.in_valid = 1'b0;
    bus.in_log2 = '0;
    bus.in_exp2 = '0;
    #2;
    total++;
    if ({bus.in_ready, bus.lut_wr_en, busy, lut_ready, overrun} !== 5'b0 || load_count !== '0 ||
        bus.log2_lut_data_out !== '0 || bus.exp2_lut_data_out !== '0) begin
      bad++;
      $display("FAIL reset_values: rdy=%b wr=%b busy=%b ready=%b ovr=%b cnt=%0d l=%h e=%h, want all 0",
        bus.in_ready, bus.lut_wr_en, busy, lut_ready, overrun, load_count, bus.log2_lut_data_out, bus.exp2_lut_data_out);
    end
    #10 rst_n = 1'b1;
    step();
  endtask
  task automatic test_idle_ignore;
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1;
      bus.in_log2 = MANT_LEN'($urandom);
      bus.in_exp2 = FLOAT_LEN'($urandom);
      step();
      total++;
      if (bus.lut_wr_en !== 1'b0 || bus.in_ready !== 1'b0 || load_count !== '0 || overrun !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL idle_ignore cyc %0d: wr=%b rdy=%b cnt=%0d ovr=%b busy=%b, want 0", i, bus.lut_wr_en, bus.in_ready, load_count, overrun, busy);
      end
    end
    bus.in_valid = 1'b0;
  endtask
  task automatic test_back_to_back;
    do_reset();
    begin_load();
    total++;
    if (bus.in_ready !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL start_to_load: rdy=%b busy=%b, want 1 1", bus.in_ready, busy);
    end
    for (int i = 0; i < LUT_SIZE; i++) begin
      bus.in_valid = 1'b1;
      bus.in_log2 = MANT_LEN'(i);
      bus.in_exp2 = FLOAT_LEN'(FP16_ONE + i);
      step();
      total++;
      if (bus.lut_wr_en !== 1'b1 || bus.log2_lut_data_out !== MANT_LEN'(i) ||
          bus.exp2_lut_data_out !== FLOAT_LEN'(FP16_ONE + i) || load_count !== CW'(i + 1)) begin
        bad++;
        $display("FAIL b2b_pulse %0d: wr=%b l=%h e=%h cnt=%0d, want 1 %h %h %0d", i, bus.lut_wr_en,
          bus.log2_lut_data_out, bus.exp2_lut_data_out, load_count, MANT_LEN'(i), FLOAT_LEN'(FP16_ONE + i), i + 1);
      end
    end
    bus.in_valid = 1'b0;
    for (int d = 0; d < DRAIN_CYC; d++) begin
      step();
      total++;
      if (bus.lut_wr_en !== 1'b0 || lut_ready !== 1'b0 || busy !== 1'b1 || bus.in_ready !== 1'b0) begin
        bad++;
        $display("FAIL b2b_drain %0d: wr=%b ready=%b busy=%b rdy=%b, want 0 0 1 0", d, bus.lut_wr_en, lut_ready, busy, bus.in_ready);
      end
    end
    step();
    total++;
    if (lut_ready !== 1'b1 || busy !== 1'b0 || bus.log2_lut_data_out !== MANT_LEN'(LUT_SIZE - 1) || load_count !== CW'(LUT_SIZE)) begin
      bad++;
      $display("FAIL b2b_ready: ready=%b busy=%b l=%h cnt=%0d, want 1 0 %h %0d", lut_ready, busy,
        bus.log2_lut_data_out, load_count, MANT_LEN'(LUT_SIZE - 1), LUT_SIZE);
    end
  endtask
  task automatic test_random_gaps;
    int acc = 0, pulses = 0, cyc = 0;
    bit v;
    do_reset();
    for (int i = 0; i < LUT_SIZE; i++) begin
      s_log2[i] = MANT_LEN'($urandom);
      s_exp2[i] = FLOAT_LEN'($urandom);
    end
    begin_load();
    while (acc < LUT_SIZE && cyc < 3000) begin
      v = 1'($urandom_range(0, 1));
      bus.in_valid = v;
      bus.in_log2 = v ? s_log2[acc] : MANT_LEN'($urandom);
      bus.in_exp2 = v ? s_exp2[acc] : FLOAT_LEN'($urandom);
      total++;
      if (bus.in_ready !== 1'b1) begin
        bad++;
        $display("FAIL gaps_ready cyc %0d: rdy=%b, want 1", cyc, bus.in_ready);
      end
      step();
      cyc++;
      if (bus.lut_wr_en === 1'b1) pulses++;
      total++;
      if (bus.lut_wr_en !== v || (v && (bus.log2_lut_data_out !== s_log2[acc] || bus.exp2_lut_data_out !== s_exp2[acc]))) begin
        bad++;
        $display("FAIL gaps_pulse entry %0d: wr=%b l=%h e=%h, want %b %h %h", acc, bus.lut_wr_en,
          bus.log2_lut_data_out, bus.exp2_lut_data_out, v, s_log2[acc], s_exp2[acc]);
      end
      if (v) acc++;
      total++;
      if (load_count !== CW'(acc)) begin
        bad++;
        $display("FAIL gaps_count cyc %0d: cnt=%0d, want %0d", cyc, load_count, acc);
      end
    end
    bus.in_valid = 1'b1;
    for (int d = 0; d < DRAIN_CYC; d++) begin
      step();
      if (bus.lut_wr_en === 1'b1) pulses++;
      total++;
      if (bus.lut_wr_en !== 1'b0 || overrun !== 1'b0) begin
        bad++;
        $display("FAIL gaps_drain_ignore %0d: wr=%b ovr=%b, want 0 0", d, bus.lut_wr_en, overrun);
      end
    end
    bus.in_valid = 1'b0;
    step();
    total++;
    if (acc != LUT_SIZE || pulses != LUT_SIZE) begin
      bad++;
      $display("FAIL gaps_total: accepted=%0d pulses=%0d, want %0d", acc, pulses, LUT_SIZE);
    end
    total++;
    if (lut_ready !== 1'b1 || overrun !== 1'b0 || bus.log2_lut_data_out !== s_log2[LUT_SIZE-1]) begin
      bad++;
      $display("FAIL gaps_done: ready=%b ovr=%b l=%h, want 1 0 %h", lut_ready, overrun, bus.log2_lut_data_out, s_log2[LUT_SIZE-1]);
    end
  endtask
  task automatic test_overrun;
    bus.in_valid = 1'b1;
    start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if (bus.lut_wr_en !== 1'b0 || lut_ready !== 1'b1 || overrun !== 1'b1 || bus.in_ready !== 1'b0 || load_count !== CW'(LUT_SIZE)) begin
        bad++;
        $display("FAIL overrun %0d: wr=%b ready=%b ovr=%b rdy=%b cnt=%0d, want 0 1 1 0 %0d", i,
          bus.lut_wr_en, lut_ready, overrun, bus.in_ready, load_count, LUT_SIZE);
      end
    end
    bus.in_valid = 1'b0;
    start = 1'b0;
    step();
    total++;
    if (overrun !== 1'b1 || lut_ready !== 1'b1) begin
      bad++;
      $display("FAIL overrun_sticky: ovr=%b ready=%b, want 1 1", overrun, lut_ready);
    end
  endtask
  task automatic test_midload_reset;
    do_reset();
    begin_load();
    for (int i = 0; i < 60; i++) begin
      bus.in_valid = 1'b1;
      bus.in_log2 = MANT_LEN'($urandom);
      bus.in_exp2 = FLOAT_LEN'($urandom);
      step();
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({bus.in_ready, bus.lut_wr_en, busy, lut_ready, overrun} !== 5'b0 || load_count !== '0 ||
        bus.log2_lut_data_out !== '0 || bus.exp2_lut_data_out !== '0) begin
      bad++;
      $display("FAIL async_reset: rdy=%b wr=%b busy=%b ready=%b ovr=%b cnt=%0d l=%h e=%h, want all 0",
        bus.in_ready, bus.lut_wr_en, busy, lut_ready, overrun, load_count, bus.log2_lut_data_out, bus.exp2_lut_data_out);
    end
    #1 rst_n = 1'b1;
    bus.in_valid = 1'b0;
    step();
    begin_load();
    for (int i = 0; i < LUT_SIZE; i++) begin
      bus.in_valid = 1'b1;
      bus.in_log2 = MANT_LEN'(i ^ 'h55);
      bus.in_exp2 = FLOAT_LEN'(i * 3);
      step();
      total++;
      if (bus.lut_wr_en !== 1'b1 || bus.log2_lut_data_out !== MANT_LEN'(i ^ 'h55) ||
          bus.exp2_lut_data_out !== FLOAT_LEN'(i * 3) || load_count !== CW'(i + 1)) begin
        bad++;
        $display("FAIL reload %0d: wr=%b l=%h e=%h cnt=%0d, want 1 %h %h %0d", i, bus.lut_wr_en,
          bus.log2_lut_data_out, bus.exp2_lut_data_out, load_count, MANT_LEN'(i ^ 'h55), FLOAT_LEN'(i * 3), i + 1);
      end
    end
    bus.in_valid = 1'b0;
    for (int d = 0; d <= DRAIN_CYC; d++) step();
    total++;
    if (lut_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reload_ready: ready=%b busy=%b, want 1 0", lut_ready, busy);
    end
  endtask
  task automatic test_restart_ignored;
    do_reset();
    begin_load();
    for (int i = 0; i < LUT_SIZE; i++) begin
      bus.in_valid = 1'b1;
      start = i == 30 || i == 31;
      bus.in_log2 = MANT_LEN'(i);
      bus.in_exp2 = FLOAT_LEN'(~i);
      step();
      total++;
      if (load_count !== CW'(i + 1) || bus.lut_wr_en !== 1'b1 || bus.exp2_lut_data_out !== FLOAT_LEN'(~i)) begin
        bad++;
        $display("FAIL restart_ignored %0d: cnt=%0d wr=%b e=%h, want %0d 1 %h", i, load_count,
          bus.lut_wr_en, bus.exp2_lut_data_out, i + 1, FLOAT_LEN'(~i));
      end
    end
    start = 1'b0;
    bus.in_valid = 1'b0;
    for (int d = 0; d <= DRAIN_CYC; d++) step();
    total++;
    if (lut_ready !== 1'b1 || overrun !== 1'b0 || load_count !== CW'(LUT_SIZE)) begin
      bad++;
      $display("FAIL restart_done: ready=%b ovr=%b cnt=%0d, want 1 0 %0d", lut_ready, overrun, load_count, LUT_SIZE);
    end
  endtask
  initial begin
    test_reset();
    test_idle_ignore();
    test_back_to_back();
    test_random_gaps();
    test_overrun();
    test_midload_reset();
    test_restart_ignored();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
